pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It collects stall requests from the IF, ID, EX and MEM stages and drives the stall vector that every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) samples. It also issues the exception flush and redirect PC. It discards an in-flight instruction fetch that returns after a flush, and it keeps stall statistics and a stuck-pipeline watchdog.

Parameters:
STALL_W, 7, stall vector width (one bit per sequencing point)
ADDR_W, 32, PC width
TIMEOUT, 1024, consecutive stall cycles before the watchdog fires

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (rst==0 resets)
stallreq_if  input  1  fetch bus not ready
stallreq_id  input  1  load-use hazard in ID
stallreq_ex  input  1  multicycle mul/div busy in EX
stallreq_mem  input  1  data bus wait in MEM
excp_valid  input  1  exception committed in MEM this cycle
excp_newpc  input  ADDR_W  handler/return address for excp_valid
ifetch_busy  input  1  fetch address accepted, data not yet returned
stall  output  STALL_W  stall vector, 1=Stop
flush  output  1  clear all pipeline registers this cycle
new_pc  output  ADDR_W  redirect PC, valid when flush=1
if_discard  output  1  drop the next returned fetch data
stall_cycles  output  32  count of cycles with stall!=0
stall_timeout  output  1  sticky watchdog flag

Behaviour:
- Stall bit map, high bit = upstream: [6] PC, [5] IF request, [4] IF wait, [3] IF/ID, [2] ID/EX, [1] EX/MEM, [0] MEM/WB.
- A register bubbles when its upstream bit is Stop and its own bit is NotStop.
- stall is combinational, same cycle as the request. The most downstream requester wins:
  - mem: 7'b1111110
  - ex: 7'b1111100
  - id: 7'b1111000
  - if: 7'b1110000
  - none: 7'b0000000
- flush = excp_valid (combinational). new_pc = excp_newpc while flush=1, else 0.
- flush overrides everything: stall is forced to 0 in a flush cycle.
- While rst is low, all outputs are 0, regardless of inputs.
- FSM, states IDLE and DISCARD, reset to IDLE:
  - IDLE: on excp_valid with ifetch_busy=1, go to DISCARD. Otherwise stay in IDLE.
  - DISCARD: if_discard=1 (registered from the state). Return to IDLE on the first cycle ifetch_busy=0.
  - excp_valid while in DISCARD: flush again and stay in DISCARD.
  - excp_valid with ifetch_busy=0: stay in IDLE, no discard.
- stall_cycles:
  - +1 on each cycle with stall!=0 (post-flush-override value).
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by reset.
- Watchdog:
  - Internal run counter increments on each stall!=0 cycle.
  - Cleared on any cycle with stall==0 or flush=1.
  - When the counter reaches TIMEOUT, stall_timeout is set on the next edge and stays 1 until reset.
  - The counter saturates at TIMEOUT.
- Simultaneous requests: only the priority encoding above applies; lower requests are absorbed.
- Reset asserted mid-DISCARD returns the FSM to IDLE and clears both counters immediately (async).

Test Plan:
- Reset with all requests high → stall=0, flush=0, if_discard=0, stall_cycles=0. Release, stallreq_id=1 → stall=7'b1111000 the same cycle.
- stallreq_if=1, stallreq_ex=1 together → stall=7'b1111100. Drop ex → 7'b1110000. Hold both for 3 cycles → stall_cycles=3.
- excp_valid=1, excp_newpc=32'hBFC00380, stallreq_mem=1 → flush=1, new_pc=32'hBFC00380, stall=0, stall_cycles not incremented.
- excp_valid with ifetch_busy=1, ifetch_busy held 2 more cycles → if_discard=1 for the 3 following cycles, 0 after ifetch_busy falls. A second excp_valid in DISCARD → flush=1 again, if_discard stays 1.
- TIMEOUT=8, stallreq_ex held 8 cycles → stall_timeout=1 on the edge after the 8th cycle and remains 1 after the request drops. A gap of one stall==0 cycle at cycle 5 → no timeout.
- Assert rst low while in DISCARD with stall_cycles=5 → if_discard=0 and stall_cycles=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage pipeline.
// Resolves per-stage stall requests into the stall vector sampled by every
// pipeline register. Issues the exception flush and redirect PC, discards a
// fetch that returns after a flush, counts stall cycles and runs a watchdog
// that flags a stuck pipeline.
module pipe_ctrl #(
  parameter int STALL_W = 7,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               excp_valid,
  input  logic [ADDR_W-1:0]  excp_newpc,
  input  logic               ifetch_busy,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [ADDR_W-1:0]  new_pc,
  output logic               if_discard,
  output logic [31:0]        stall_cycles,
  output logic               stall_timeout
);

  // Stop masks: the requesting stage and everything upstream of it stop, so
  // the register just downstream of the requester receives a bubble.
  localparam logic [STALL_W-1:0] S_MEM = ~(STALL_W'(1));
  localparam logic [STALL_W-1:0] S_EX  = ~(STALL_W'(3));
  localparam logic [STALL_W-1:0] S_ID  = ~(STALL_W'(7));
  localparam logic [STALL_W-1:0] S_IF  = ~(STALL_W'(15));

  localparam int                RUN_W   = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(TIMEOUT);

  typedef enum logic {IDLE, DISCARD} state_t;

  state_t             state;
  logic [STALL_W-1:0] stall_req;
  logic               stall_active;
  logic [RUN_W-1:0]   run_cnt;

  // Saturating increment for the 32-bit stall statistics counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Saturating increment for the watchdog run counter.
  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (v == RUN_MAX) ? v : v + RUN_W'(1);
  endfunction

  // Priority resolve: the most downstream requester decides the mask.
  always_comb begin
    stall_req = '0;
    if (stallreq_mem)      stall_req = S_MEM;
    else if (stallreq_ex)  stall_req = S_EX;
    else if (stallreq_id)  stall_req = S_ID;
    else if (stallreq_if)  stall_req = S_IF;
  end

  // A flush clears the pipe, so it wins over any stall; reset silences all.
  assign flush        = rst & excp_valid;
  assign stall        = (rst && !excp_valid) ? stall_req : '0;
  assign new_pc       = flush ? excp_newpc : '0;
  assign stall_active = |stall;

  // Discard FSM: a flush while a fetch is outstanding marks that fetch's data
  // as stale until the bus goes idle; a further flush keeps the discard armed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      if_discard <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (excp_valid && ifetch_busy) begin
            state      <= DISCARD;
            if_discard <= 1'b1;
          end
        end
        DISCARD: begin
          if (!excp_valid && !ifetch_busy) begin
            state      <= IDLE;
            if_discard <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          if_discard <= 1'b0;
        end
      endcase
    end
  end

  // Stall statistics: every cycle with a non-zero stall vector, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall_active) begin
      stall_cycles <= sat_inc32(stall_cycles);
    end
  end

  // Watchdog: run length of consecutive stall cycles; once the run has
  // reached TIMEOUT the sticky flag is raised on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt       <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (run_cnt == RUN_MAX) stall_timeout <= 1'b1;
      if (!stall_active || flush) run_cnt <= '0;
      else                        run_cnt <= sat_inc_run(run_cnt);
    end
  end

endmodule
